// File: rtl/rv32_pkg.sv
// Shared RV32I constants and the fetch-queue entry layout used by the fetch stage.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with show-ahead head, flush and occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited word fetch, in-order response queue, redirect flush.
// Define FETCH_BYPASS_EN to let a response reach decode in its arrival cycle when the queue is empty.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            req_stale_q, req_stale_d;

    logic            req_fire;
    logic            rsp_keep;
    logic            bypass;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count, count_d;
    logic            credit_ok;
    fetch_entry_t    push_entry, head_entry, out_entry;

    assign req_fire   = req_valid_q & imem_req_ready;
    assign rsp_keep   = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

`ifdef FETCH_BYPASS_EN
    assign bypass    = fifo_empty & rsp_keep;
    assign out_entry = fifo_empty ? push_entry : head_entry;
`else
    assign bypass    = 1'b0;
    assign out_entry = head_entry;
`endif

    assign dec_valid    = ~fifo_empty | bypass;
    assign fifo_pop     = ~fifo_empty & dec_ready;
    assign fifo_push    = rsp_keep & ~(bypass & dec_ready);
    assign dec_instr    = dec_valid ? out_entry.instr : '0;
    assign dec_pc       = dec_valid ? out_entry.pc : '0;
    assign dec_pc_plus4 = dec_valid ? out_entry.pc + 32'd4 : '0;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (FETCH_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (push_entry),
        .pop     (fifo_pop),
        .rd_data (head_entry),
        .flush   (redirect_valid),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A stale request was issued before a redirect: it is already counted in discard,
    // so accepting it neither advances the PC nor adds an outstanding credit.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            fetch_pc_d    = word_align(redirect_pc);
            rsp_pc_d      = word_align(redirect_pc);
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q + CW'(req_valid_q & ~req_stale_q)
                          - CW'(imem_rsp_valid);
        end else begin
            if (req_fire && !req_stale_q) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                outstanding_d = outstanding_q + 1'b1;
            end
            if (imem_rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    outstanding_d = outstanding_d - 1'b1;
                    rsp_pc_d      = rsp_pc_q + 32'd4;
                end
            end
        end
    end

    always_comb begin
        count_d   = redirect_valid ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        credit_ok = ({1'b0, outstanding_d} + {1'b0, count_d}) < (CW + 1)'(DEPTH);
        if (req_valid_q && !imem_req_ready) begin
            req_valid_d = 1'b1;
            req_addr_d  = req_addr_q;
            req_stale_d = req_stale_q | redirect_valid;
        end else begin
            req_valid_d = credit_ok;
            req_addr_d  = fetch_pc_d;
            req_stale_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_stale_q   <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_stale_q   <= req_stale_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a 1-cycle-latency instruction memory returning addr^0xA5.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc, dec_pc_plus4;

    int n_checks = 0;
    int n_errors = 0;
    int fire_cnt;

`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            fire_cnt       <= 0;
        end else begin
            imem_rsp_valid <= imem_req_valid && imem_req_ready;
            imem_rsp_data  <= imem_req_addr ^ 32'h0000_00A5;
            if (imem_req_valid && imem_req_ready) fire_cnt <= fire_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready)
            $display("dec pc=%08h instr=%08h pc4=%08h", dec_pc, dec_instr, dec_pc_plus4);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic expect_dec(input string tag, input logic [31:0] pc, output int waited);
        waited = 0;
        while (!(dec_valid && dec_ready) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!(dec_valid && dec_ready)) begin
            check_eq({tag, "_valid"}, 32'(dec_valid), 32'd1);
        end else begin
            check_eq({tag, "_pc"}, dec_pc, pc);
            check_eq({tag, "_instr"}, dec_instr, pc ^ 32'h0000_00A5);
            check_eq({tag, "_pc4"}, dec_pc_plus4, pc + 32'd4);
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(imem_req_valid), 32'd1);
        check_eq({tag, "_addr"}, imem_req_addr, addr);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    task automatic apply_reset(input logic rdy, input logic drdy);
        rst_n          = 1'b0;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state, then first request and in-order stream
        @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("rst_dec_instr", dec_instr, 32'd0);
        check_eq("rst_dec_pc", dec_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("t1_first", 32'h0);
        check_eq("t1_dec_idle", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            expect_dec("t2", 32'(i * 4), w);
            if (i > 0) check_eq("t2_rate", 32'(w), 32'd0);
        end

        // Redirect with responses in flight
        do_redirect(32'h0000_0100);
        check_eq("t4_flush", 32'(dec_valid), 32'd0);
        wait_req("t4_req", 32'h0000_0100);
        expect_dec("t4_a", 32'h0000_0100, w);
        expect_dec("t4_b", 32'h0000_0104, w);

        // Unaligned redirect target and PC wrap
        do_redirect(32'h0000_0203);
        wait_req("t5_align", 32'h0000_0200);
        expect_dec("t5_a", 32'h0000_0200, w);
        do_redirect(32'hFFFF_FFFC);
        wait_req("t5_top", 32'hFFFF_FFFC);
        expect_dec("t5_w0", 32'hFFFF_FFFC, w);
        expect_dec("t5_w1", 32'h0000_0000, w);
        expect_dec("t5_w2", 32'h0000_0004, w);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("t6_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("t6_dec_instr", dec_instr, 32'd0);
        check_eq("t6_dec_pc", dec_pc, 32'd0);
        check_eq("t6_dec_pc4", dec_pc_plus4, 32'd0);
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Held request, then single-response latency into an empty queue
        repeat (3) @(negedge clk);
        check_eq("t7_hold_valid", 32'(imem_req_valid), 32'd1);
        check_eq("t7_hold_addr", imem_req_addr, 32'h0);
        check_eq("t7_no_fire", 32'(fire_cnt), 32'd0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check_eq("t7_lat_n_valid", 32'(dec_valid), 32'(BYP));
        check_eq("t7_lat_n_instr", dec_instr, BYP ? 32'h0000_00A5 : 32'h0);
        @(negedge clk);
        check_eq("t7_lat_n1_valid", 32'(dec_valid), 32'(!BYP));
        check_eq("t7_lat_n1_instr", dec_instr, BYP ? 32'h0 : 32'h0000_00A5);

        // Decode stall fills the queue to DEPTH and stops requests
        apply_reset(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("t3_fires", 32'(fire_cnt), 32'd4);
        check_eq("t3_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("t3_dec_valid", 32'(dec_valid), 32'd1);
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_dec("t3", 32'(i * 4), w);
            check_eq("t3_rate", 32'(w), 32'd0);
        end

        // Redirect while a request is held unaccepted
        apply_reset(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        do_redirect(32'h0000_0300);
        check_eq("t8_stale_valid", 32'(imem_req_valid), 32'd1);
        check_eq("t8_stale_addr", imem_req_addr, 32'h0);
        check_eq("t8_dec_idle", 32'(dec_valid), 32'd0);
        imem_req_ready = 1'b1;
        expect_dec("t8_a", 32'h0000_0300, w);
        expect_dec("t8_b", 32'h0000_0304, w);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
